// File: rtl/basilisk_divide_round_pkg.sv
// ============================================================================
// basilisk_divide_round_pkg : shared constants for the divider finishing stage
// Revision: 1.0
// ============================================================================
`default_nettype none

package basilisk_divide_round_pkg;

  localparam int FFLAG_NV = 4;
  localparam int FFLAG_DZ = 3;
  localparam int FFLAG_OF = 2;
  localparam int FFLAG_UF = 1;
  localparam int FFLAG_NX = 0;

  typedef enum logic [2:0] {
    RM_RNE = 3'd0,
    RM_RTZ = 3'd1,
    RM_RDN = 3'd2,
    RM_RUP = 3'd3,
    RM_RMM = 3'd4
  } rm_e;

  // Quiet NaN with only the top fraction bit set; caller truncates to its width.
  function automatic logic [63:0] canonical_nan(input int exp_w, input int mant_w);
    logic [63:0] v;
    v = ((64'd1 << exp_w) - 64'd1) << mant_w;
    v = v | (64'd1 << (mant_w - 1));
    return v;
  endfunction

endpackage

`default_nettype wire

// File: rtl/basilisk_round_robin_arbiter.sv
// ============================================================================
// basilisk_round_robin_arbiter : one-hot round-robin grant over request lines
// Revision: 1.0
// ============================================================================
`default_nettype none

module basilisk_round_robin_arbiter #(
  parameter int NUM_CHANNELS = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_CHANNELS-1:0] i_request,
  input  logic                    i_advance,
  output logic [NUM_CHANNELS-1:0] o_grant
);

  localparam int PTR_WIDTH = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;

  logic [PTR_WIDTH-1:0] r_ptr;
  logic [PTR_WIDTH-1:0] w_grant_idx;

  // Scan from the farthest offset down so the nearest request at/after r_ptr wins.
  always_comb begin : p_grant
    int idx;
    idx         = 0;
    o_grant     = '0;
    w_grant_idx = '0;
    for (int off = NUM_CHANNELS - 1; off >= 0; off--) begin
      idx = int'(r_ptr) + off;
      if (idx >= NUM_CHANNELS) begin
        idx = idx - NUM_CHANNELS;
      end
      if (i_request[idx]) begin
        o_grant      = '0;
        o_grant[idx] = 1'b1;
        w_grant_idx  = PTR_WIDTH'(idx);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (i_advance) begin
      r_ptr <= (w_grant_idx == PTR_WIDTH'(NUM_CHANNELS - 1)) ? '0 : w_grant_idx + 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/std_flow_stage.sv
// ============================================================================
// std_flow_stage : one elastic valid/ready slice, registered or pass-through
// Revision: 1.0
// ============================================================================
`default_nettype none

module std_flow_stage #(
  parameter int WIDTH = 8,
  parameter int MODE  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_data
);

  generate
    if (MODE != 0) begin : g_register
      logic             r_valid;
      logic [WIDTH-1:0] r_data;

      // Loads when empty or when the downstream slice takes the current word.
      assign o_ready = ~r_valid | i_ready;
      assign o_valid = r_valid;
      assign o_data  = r_data;

      always_ff @(posedge clk) begin
        if (rst) begin
          r_valid <= 1'b0;
        end else if (o_ready) begin
          r_valid <= i_valid;
          if (i_valid) begin
            r_data <= i_data;
          end
        end
      end
    end else begin : g_bypass
      logic w_unused;
      assign w_unused = clk ^ rst;
      assign o_ready  = i_ready;
      assign o_valid  = i_valid;
      assign o_data   = i_data;
    end
  endgenerate

endmodule

`default_nettype wire

// File: rtl/basilisk_divide_round.sv
// ============================================================================
// basilisk_divide_round : arbitrate, normalise, round and flag divide results
// Revision: 1.0
// ============================================================================
`default_nettype none

module basilisk_divide_round
  import basilisk_divide_round_pkg::*;
#(
  parameter int NUM_CHANNELS         = 2,
  parameter int PIPELINE_DEPTH       = 2,
  parameter int EXP_WIDTH            = 8,
  parameter int MANT_WIDTH           = 23,
  parameter int OUTPUT_REGISTER_MODE = 1,
  parameter int DEST_ADDR_WIDTH      = 5,
  localparam int CMD_WIDTH = EXP_WIDTH + MANT_WIDTH + DEST_ADDR_WIDTH + 15,
  localparam int RES_WIDTH = EXP_WIDTH + MANT_WIDTH + DEST_ADDR_WIDTH + 6
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [NUM_CHANNELS-1:0]                divide_operation_command_valid,
  output logic [NUM_CHANNELS-1:0]                divide_operation_command_ready,
  input  logic [NUM_CHANNELS-1:0][CMD_WIDTH-1:0] divide_operation_command_data,
  output logic                                   divide_result_command_valid,
  input  logic                                   divide_result_command_ready,
  output logic [RES_WIDTH-1:0]                   divide_result_command_data,
  output logic                                   idle
);

  typedef struct packed {
    logic                        sign;
    logic signed [EXP_WIDTH+1:0] exp;
    logic [MANT_WIDTH+2:0]       q;
    logic                        sticky;
    logic                        nan;
    logic                        inf;
    logic                        zero;
    logic                        div_by_zero;
    logic                        invalid;
    logic [2:0]                  rm;
    logic [DEST_ADDR_WIDTH-1:0]  dest_reg_addr;
  } basilisk_divide_round_command_t;

  typedef struct packed {
    logic [EXP_WIDTH+MANT_WIDTH:0] result;
    logic [4:0]                    fflags;
    logic [DEST_ADDR_WIDTH-1:0]    dest_reg_addr;
  } basilisk_float_result_t;

  localparam int PIPE_WIDTH = CMD_WIDTH;
  localparam int PAD_WIDTH  = CMD_WIDTH - RES_WIDTH;

  localparam logic signed [EXP_WIDTH+1:0] c_exp_one  = (EXP_WIDTH + 2)'(1);
  localparam logic signed [EXP_WIDTH+1:0] c_exp_zero = '0;
  localparam logic signed [EXP_WIDTH+1:0] c_exp_inf  = (EXP_WIDTH + 2)'((1 << EXP_WIDTH) - 1);
  localparam logic [EXP_WIDTH+MANT_WIDTH:0] c_qnan =
    (EXP_WIDTH + MANT_WIDTH + 1)'(canonical_nan(EXP_WIDTH, MANT_WIDTH));

  logic [NUM_CHANNELS-1:0]        w_grant;
  logic                           w_any_valid;
  logic                           w_advance;
  basilisk_divide_round_command_t w_sel;
  basilisk_divide_round_command_t w_norm;
  basilisk_divide_round_command_t w_rin;
  basilisk_float_result_t         w_rounded;

  logic [MANT_WIDTH-1:0]       w_frac;
  logic                        w_guard;
  logic                        w_rbit;
  logic                        w_nx;
  logic                        w_inc;
  logic                        w_to_inf;
  logic [MANT_WIDTH:0]         w_mant_sum;
  logic signed [EXP_WIDTH+1:0] w_exp_r;
  logic                        w_of;
  logic                        w_uf;

  logic [PIPELINE_DEPTH-1:0] w_stage_valid_in;
  logic [PIPELINE_DEPTH-1:0] w_stage_ready_out;
  logic [PIPELINE_DEPTH-1:0] w_stage_valid_out;
  logic [PIPELINE_DEPTH-1:0] w_stage_ready_in;
  logic [PIPE_WIDTH-1:0]     w_stage_data_in  [PIPELINE_DEPTH];
  logic [PIPE_WIDTH-1:0]     w_stage_data_out [PIPELINE_DEPTH];
  logic                      w_out_stage_ready;
  logic                      w_unused;

  assign w_any_valid = |divide_operation_command_valid;
  assign w_advance   = w_any_valid & w_stage_ready_out[0] & ~rst;
  assign divide_operation_command_ready =
    w_grant & {NUM_CHANNELS{w_stage_ready_out[0] & ~rst}};

  basilisk_round_robin_arbiter #(
    .NUM_CHANNELS(NUM_CHANNELS)
  ) u_arbiter (
    .clk      (clk),
    .rst      (rst),
    .i_request(divide_operation_command_valid),
    .i_advance(w_advance),
    .o_grant  (w_grant)
  );

  always_comb begin
    w_sel = '0;
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      if (w_grant[c]) begin
        w_sel = divide_operation_command_data[c];
      end
    end
  end

  // A left shift only drops the zero integer bit, so sticky carries through as is.
  always_comb begin
    w_norm = w_sel;
    if (!w_sel.q[MANT_WIDTH+2]) begin
      w_norm.q   = {w_sel.q[MANT_WIDTH+1:0], 1'b0};
      w_norm.exp = w_sel.exp - c_exp_one;
    end
  end

  always_comb begin
    w_frac   = w_rin.q[MANT_WIDTH+1:2];
    w_guard  = w_rin.q[1];
    w_rbit   = w_rin.q[0];
    w_nx     = w_guard | w_rbit | w_rin.sticky;
    w_inc    = 1'b0;
    w_to_inf = 1'b0;
    case (w_rin.rm)
      RM_RNE: begin
        w_inc    = w_guard & (w_rbit | w_rin.sticky | w_frac[0]);
        w_to_inf = 1'b1;
      end
      RM_RDN: begin
        w_inc    = w_nx & w_rin.sign;
        w_to_inf = w_rin.sign;
      end
      RM_RUP: begin
        w_inc    = w_nx & ~w_rin.sign;
        w_to_inf = ~w_rin.sign;
      end
      RM_RMM: begin
        w_inc    = w_guard;
        w_to_inf = 1'b1;
      end
      default: ;
    endcase
    w_mant_sum = {1'b0, w_frac} + {{MANT_WIDTH{1'b0}}, w_inc};
    w_exp_r    = w_rin.exp + {{(EXP_WIDTH + 1){1'b0}}, w_mant_sum[MANT_WIDTH]};
    w_of       = (w_exp_r >= c_exp_inf);
    w_uf       = (w_exp_r <= c_exp_zero);

    w_rounded.dest_reg_addr    = w_rin.dest_reg_addr;
    w_rounded.result           = {w_rin.sign, w_exp_r[EXP_WIDTH-1:0], w_mant_sum[MANT_WIDTH-1:0]};
    w_rounded.fflags           = '0;
    w_rounded.fflags[FFLAG_NX] = w_nx;

    if (w_rin.rm > 3'd4) begin
      w_rounded.result           = c_qnan;
      w_rounded.fflags           = '0;
      w_rounded.fflags[FFLAG_NV] = 1'b1;
    end else if (w_rin.nan | w_rin.invalid) begin
      w_rounded.result           = c_qnan;
      w_rounded.fflags           = '0;
      w_rounded.fflags[FFLAG_NV] = w_rin.invalid;
    end else if (w_rin.div_by_zero) begin
      w_rounded.result           = {w_rin.sign, {EXP_WIDTH{1'b1}}, {MANT_WIDTH{1'b0}}};
      w_rounded.fflags           = '0;
      w_rounded.fflags[FFLAG_DZ] = 1'b1;
    end else if (w_rin.inf) begin
      w_rounded.result = {w_rin.sign, {EXP_WIDTH{1'b1}}, {MANT_WIDTH{1'b0}}};
      w_rounded.fflags = '0;
    end else if (w_rin.zero) begin
      w_rounded.result = {w_rin.sign, {(EXP_WIDTH + MANT_WIDTH){1'b0}}};
      w_rounded.fflags = '0;
    end else if (w_of) begin
      w_rounded.result = w_to_inf ?
        {w_rin.sign, {EXP_WIDTH{1'b1}}, {MANT_WIDTH{1'b0}}} :
        {w_rin.sign, {(EXP_WIDTH - 1){1'b1}}, 1'b0, {MANT_WIDTH{1'b1}}};
      w_rounded.fflags           = '0;
      w_rounded.fflags[FFLAG_OF] = 1'b1;
      w_rounded.fflags[FFLAG_NX] = 1'b1;
    end else if (w_uf) begin
      w_rounded.result           = {w_rin.sign, {(EXP_WIDTH + MANT_WIDTH){1'b0}}};
      w_rounded.fflags           = '0;
      w_rounded.fflags[FFLAG_UF] = 1'b1;
      w_rounded.fflags[FFLAG_NX] = 1'b1;
    end
  end

  // Rounding consumes stage 1 when there is a second stage to absorb it.
  generate
    if (PIPELINE_DEPTH >= 2) begin : g_round_late
      assign w_rin = w_stage_data_out[0];
    end else begin : g_round_early
      assign w_rin = w_norm;
    end
  endgenerate

  generate
    for (genvar i = 0; i < PIPELINE_DEPTH; i++) begin : g_stage
      if (i == 0) begin : g_first
        assign w_stage_valid_in[i] = w_any_valid & ~rst;
      end else begin : g_chain
        assign w_stage_valid_in[i] = w_stage_valid_out[i-1];
      end

      if (i == 0 && PIPELINE_DEPTH >= 2) begin : g_data_norm
        assign w_stage_data_in[i] = w_norm;
      end else if (i <= 1) begin : g_data_round
        assign w_stage_data_in[i] = {{PAD_WIDTH{1'b0}}, w_rounded};
      end else begin : g_data_pass
        assign w_stage_data_in[i] = w_stage_data_out[i-1];
      end

      if (i == PIPELINE_DEPTH - 1) begin : g_ready_last
        assign w_stage_ready_in[i] = w_out_stage_ready;
      end else begin : g_ready_chain
        assign w_stage_ready_in[i] = w_stage_ready_out[i+1];
      end

      std_flow_stage #(
        .WIDTH(PIPE_WIDTH),
        .MODE (1)
      ) u_stage (
        .clk    (clk),
        .rst    (rst),
        .i_valid(w_stage_valid_in[i]),
        .o_ready(w_stage_ready_out[i]),
        .i_data (w_stage_data_in[i]),
        .o_valid(w_stage_valid_out[i]),
        .i_ready(w_stage_ready_in[i]),
        .o_data (w_stage_data_out[i])
      );
    end
  endgenerate

  std_flow_stage #(
    .WIDTH(RES_WIDTH),
    .MODE (OUTPUT_REGISTER_MODE)
  ) u_output_stage (
    .clk    (clk),
    .rst    (rst),
    .i_valid(w_stage_valid_out[PIPELINE_DEPTH-1]),
    .o_ready(w_out_stage_ready),
    .i_data (w_stage_data_out[PIPELINE_DEPTH-1][RES_WIDTH-1:0]),
    .o_valid(divide_result_command_valid),
    .i_ready(divide_result_command_ready),
    .o_data (divide_result_command_data)
  );

  assign idle     = ~(|w_stage_valid_out | divide_result_command_valid);
  assign w_unused = ^{w_stage_data_out[PIPELINE_DEPTH-1][PIPE_WIDTH-1:RES_WIDTH], w_rin.q[MANT_WIDTH+2]};

endmodule

`default_nettype wire
